memory_address_unit: RTL and testbench

Parametrised memory address register (MAR) sitting between the program counter, the internal data bus and the memory address port. It widens the address to any whole multiple of the bus width. Address bytes can be loaded directly by lane or as an atomic little-endian operand sequence. The register also supports in-place increment and decrement with a wrap indication, for block and indexed accesses.

---
 rtl/memory_address_unit.sv | 136 +++++++++++++
 tb/tb_memory_address_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_address_unit.sv
// memory_address_unit
//   Memory address register between the program counter, the internal data
//   bus and the memory address port. The address is NBYTES bus lanes wide.
//   It can be loaded from the PC, lane by lane, or as an atomic little-endian
//   byte sequence. It also increments and decrements in place and reports
//   when either operation wraps.
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   load_pc             copy program_counter_in into address_out
//   program_counter_in  PC value (ADDR_WIDTH)
//   bus_in              data bus (DATA_WIDTH)
//   load_byte           write bus_in into lane byte_sel of address_out
//   byte_sel            lane index, lane 0 = least significant
//   seq_start           begin an atomic sequential load
//   seq_load            next byte of the active sequence
//   inc / dec           address_out +1 / -1, modulo 2^ADDR_WIDTH
//   address_out         current memory address (registered)
//   seq_busy            sequence in progress (registered)
//   wrap                one-cycle pulse after a wrapping inc/dec (registered)
module memory_address_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  localparam int unsigned NBYTES = ADDR_WIDTH / DATA_WIDTH,
  localparam int unsigned SEL_W  = (NBYTES > 2) ? $clog2(NBYTES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_pc,
  input  logic [ADDR_WIDTH-1:0] program_counter_in,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  load_byte,
  input  logic [SEL_W-1:0]      byte_sel,
  input  logic                  seq_start,
  input  logic                  seq_load,
  input  logic                  inc,
  input  logic                  dec,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic                  seq_busy,
  output logic                  wrap
);

  localparam int unsigned STG_W = ADDR_WIDTH - DATA_WIDTH;

  if (((ADDR_WIDTH % DATA_WIDTH) != 0) || (NBYTES < 2)) begin : g_bad_cfg
    $error("memory_address_unit: ADDR_WIDTH must be a multiple (>=2) of DATA_WIDTH");
  end

  typedef enum logic {
    ST_IDLE,
    ST_SEQ
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [SEL_W-1:0]      r_cnt,   w_cnt_nxt;
  logic [STG_W-1:0]      r_stage, w_stage_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
  logic                  r_wrap,  w_wrap_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
      r_addr  <= RESET_ADDR;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_addr  <= w_addr_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Commands are decoded in strict priority order; only the first asserted
  // one acts. Bytes of a sequence go to r_stage so address_out only ever
  // changes to the fully assembled value on the final byte.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_addr_nxt  = r_addr;
    w_wrap_nxt  = 1'b0;

    if (seq_start) begin
      w_state_nxt = ST_SEQ;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
    end else if (load_pc) begin
      w_addr_nxt  = program_counter_in;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
    end else if (load_byte) begin
      // Out-of-range lane matches no iteration: address held, sequence still aborted.
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (byte_sel == SEL_W'(i)) begin
          w_addr_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bus_in;
        end
      end
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
    end else if (seq_load) begin
      if (r_state == ST_SEQ) begin
        if (r_cnt == SEL_W'(NBYTES - 1)) begin
          w_addr_nxt  = {bus_in, r_stage};
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end else begin
          for (int unsigned i = 0; i < NBYTES - 1; i++) begin
            if (r_cnt == SEL_W'(i)) begin
              w_stage_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bus_in;
            end
          end
          w_cnt_nxt = r_cnt + SEL_W'(1);
        end
      end
    end else if (inc && !dec) begin
      w_addr_nxt = r_addr + ADDR_WIDTH'(1);
      w_wrap_nxt = &r_addr;
    end else if (dec && !inc) begin
      w_addr_nxt = r_addr - ADDR_WIDTH'(1);
      w_wrap_nxt = ~|r_addr;
    end
  end

  assign address_out = r_addr;
  assign seq_busy    = (r_state == ST_SEQ);
  assign wrap        = r_wrap;

endmodule

// File: tb/tb_memory_address_unit.sv
// tb_memory_address_unit
//   Drives a 16-bit (2-lane) and a 24-bit (3-lane) instance with shared
//   commands and compares both against an arithmetic reference model.
module tb_memory_address_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_pc, load_byte, seq_start, seq_load, inc, dec;
  logic [7:0]  bus_in;
  logic [15:0] pc_a;
  logic [23:0] pc_b;
  logic [0:0]  sel_a;
  logic [1:0]  sel_b;
  logic [15:0] addr_a;
  logic [23:0] addr_b;
  logic        busy_a, busy_b, wrap_a, wrap_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per instance
  longint ma_addr, mb_addr, ma_stg, mb_stg;
  bit     ma_busy, mb_busy, ma_wrap, mb_wrap;
  int     ma_cnt, mb_cnt;

  memory_address_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RESET_ADDR(16'h0000)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .load_pc(load_pc), .program_counter_in(pc_a),
    .bus_in(bus_in), .load_byte(load_byte), .byte_sel(sel_a), .seq_start(seq_start),
    .seq_load(seq_load), .inc(inc), .dec(dec), .address_out(addr_a),
    .seq_busy(busy_a), .wrap(wrap_a));

  memory_address_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .RESET_ADDR(24'h000000)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .load_pc(load_pc), .program_counter_in(pc_b),
    .bus_in(bus_in), .load_byte(load_byte), .byte_sel(sel_b), .seq_start(seq_start),
    .seq_load(seq_load), .inc(inc), .dec(dec), .address_out(addr_b),
    .seq_busy(busy_b), .wrap(wrap_b));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ma_addr = 0; ma_busy = 0; ma_wrap = 0; ma_cnt = 0; ma_stg = 0;
    mb_addr = 0; mb_busy = 0; mb_wrap = 0; mb_cnt = 0; mb_stg = 0;
  endtask

  // Behaviour of one edge for an instance with nb lanes of 8 bits.
  task automatic model_step(input int nb, input int sel, input longint pcv,
                            inout longint addr, inout bit busy, inout bit wr,
                            inout int cnt, inout longint stg);
    longint mask;
    mask = (longint'(1) << (8 * nb)) - 1;
    wr = 0;
    if (seq_start) begin
      busy = 1; cnt = 0; stg = 0;
    end else if (load_pc) begin
      addr = pcv & mask;
      busy = 0; cnt = 0; stg = 0;
    end else if (load_byte) begin
      if (sel < nb)
        addr = (addr & ~(longint'(255) << (8 * sel))) | (longint'(bus_in) << (8 * sel));
      busy = 0; cnt = 0; stg = 0;
    end else if (seq_load) begin
      if (busy) begin
        if (cnt < nb - 1) begin
          stg = stg + (longint'(bus_in) << (8 * cnt));
          cnt = cnt + 1;
        end else begin
          addr = stg + (longint'(bus_in) << (8 * cnt));
          busy = 0; cnt = 0; stg = 0;
        end
      end
    end else if (inc && !dec) begin
      wr = (addr == mask);
      addr = (addr + 1) & mask;
    end else if (dec && !inc) begin
      wr = (addr == 0);
      addr = (addr - 1) & mask;
    end
  endtask

  task automatic check_all();
    chk("addr_a", 64'(addr_a), ma_addr);
    chk("busy_a", 64'(busy_a), 64'(ma_busy));
    chk("wrap_a", 64'(wrap_a), 64'(ma_wrap));
    chk("addr_b", 64'(addr_b), mb_addr);
    chk("busy_b", 64'(busy_b), 64'(mb_busy));
    chk("wrap_b", 64'(wrap_b), 64'(mb_wrap));
  endtask

  task automatic idle_inputs();
    load_pc = 0; load_byte = 0; seq_start = 0; seq_load = 0; inc = 0; dec = 0;
  endtask

  // One clock edge: sample 1 time unit after, advance model, compare.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(2, int'(sel_a), longint'(pc_a), ma_addr, ma_busy, ma_wrap, ma_cnt, ma_stg);
    model_step(3, int'(sel_b), longint'(pc_b), mb_addr, mb_busy, mb_wrap, mb_cnt, mb_stg);
    check_all();
    idle_inputs();
  endtask

  task automatic cmd(input bit ss, input bit lp, input bit lb, input bit sl,
                     input bit i, input bit d, input logic [7:0] b,
                     input logic [23:0] pc, input logic [1:0] sel);
    seq_start = ss; load_pc = lp; load_byte = lb; seq_load = sl; inc = i; dec = d;
    bus_in = b; pc_a = pc[15:0]; pc_b = pc; sel_a = sel[0:0]; sel_b = sel;
    cycle();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic mid_reset();
    #3 reset_n = 0;
    #1;
    model_reset();
    check_all();
    #2 reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    bus_in = 0; pc_a = 0; pc_b = 0; sel_a = 0; sel_b = 0;
    reset_n = 0;
    model_reset();
    #12;
    check_all();
    #10 reset_n = 1;

    cmd(0,1,0,0,0,0, 8'h00, 24'h001234, 2'd0);
    chk("pc_1234", 64'(addr_a), 64'h1234);

    // Sequence with an idle gap
    cmd(1,0,0,0,0,0, 8'h00, 24'h0, 2'd0);
    cmd(0,0,0,1,0,0, 8'hCD, 24'h0, 2'd0);
    cycle();
    cmd(0,0,0,1,0,0, 8'hAB, 24'h0, 2'd0);
    chk("seq_abcd", 64'(addr_a), 64'hABCD);

    // Abort by load_pc, then stray seq_load
    cmd(1,0,0,0,0,0, 8'h00, 24'h0, 2'd0);
    cmd(0,0,0,1,0,0, 8'h11, 24'h0, 2'd0);
    cmd(0,1,0,0,0,0, 8'h00, 24'h000F00, 2'd0);
    cmd(0,0,0,1,0,0, 8'h22, 24'h0, 2'd0);
    chk("abort_0f00", 64'(addr_a), 64'h0F00);

    // Lane load
    cmd(0,1,0,0,0,0, 8'h00, 24'h00ABCD, 2'd0);
    cmd(0,0,1,0,0,0, 8'h7E, 24'h0, 2'd1);
    chk("lane_7ecd", 64'(addr_a), 64'h7ECD);
    cmd(0,0,1,0,0,0, 8'h99, 24'h0, 2'd3);   // out-of-range lane for the 3-lane instance

    // inc/dec and wrap
    cmd(0,1,0,0,0,0, 8'h00, 24'h0000FF, 2'd0);
    cmd(0,0,0,0,1,0, 8'h00, 24'h0, 2'd0);
    chk("inc_0100", 64'(addr_a), 64'h0100);
    cmd(0,1,0,0,0,0, 8'h00, 24'hFFFFFF, 2'd0);
    cmd(0,0,0,0,1,0, 8'h00, 24'h0, 2'd0);
    chk("wrap_inc", 64'(wrap_a), 64'h1);
    cycle();
    cmd(0,1,0,0,0,0, 8'h00, 24'h000000, 2'd0);
    cmd(0,0,0,0,0,1, 8'h00, 24'h0, 2'd0);
    chk("dec_ffff", 64'(addr_a), 64'hFFFF);
    cmd(0,0,0,0,1,1, 8'h00, 24'h0, 2'd0);

    // Priority, then 3-byte sequence on the wide instance
    cmd(1,1,0,0,1,0, 8'h00, 24'h005555, 2'd0);
    cmd(0,0,0,1,0,0, 8'h56, 24'h0, 2'd0);
    cmd(0,0,0,1,0,0, 8'h34, 24'h0, 2'd0);
    cmd(0,0,0,1,0,0, 8'h12, 24'h0, 2'd0);
    chk("seq_123456", 64'(addr_b), 64'h123456);

    // Reset in the middle of a sequence leaves both idle
    cmd(1,0,0,0,0,0, 8'h00, 24'h0, 2'd0);
    mid_reset();
    cmd(0,0,0,1,0,0, 8'h77, 24'h0, 2'd0);

    // Randomized commands
    for (int n = 0; n < 500; n++) begin
      bit ss, lp, lb, sl, ic, dc;
      logic [23:0] pc;
      int pk;
      ss = ($urandom_range(0, 15) == 0);
      lp = ($urandom_range(0, 9) == 0);
      lb = ($urandom_range(0, 9) == 0);
      sl = ($urandom_range(0, 2) == 0);
      ic = ($urandom_range(0, 3) == 0);
      dc = ($urandom_range(0, 3) == 0);
      if (sl) begin ic = 0; dc = 0; end
      pk = $urandom_range(0, 3);
      pc = (pk == 0) ? 24'h000000 : (pk == 1) ? 24'hFFFFFF : 24'($urandom);
      cmd(ss, lp, lb, sl, ic, dc, 8'($urandom), pc, 2'($urandom));
      if ($urandom_range(0, 79) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
